// File: rtl/instr_trace_buf_if.sv
// Bundle of the writeback capture, trigger, arm and readout signals of the
// instruction trace buffer. master drives capture/control, slave is the buffer.
interface instr_trace_buf_if #(
   parameter int AW = 4
);
   logic          wb_valid;
   logic [31:0]   wb_pc;
   logic [31:0]   wb_instr;
   logic          trig_en;
   logic [31:0]   trig_instr;
   logic [31:0]   trig_mask;
   logic          arm;
   logic          rd_req;
   logic          rd_valid;
   logic [31:0]   rd_pc;
   logic [31:0]   rd_instr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic          overflow;

   modport master (
      output wb_valid, wb_pc, wb_instr, trig_en, trig_instr, trig_mask, arm, rd_req,
      input  rd_valid, rd_pc, rd_instr, count, state, overflow
   );

   modport slave (
      input  wb_valid, wb_pc, wb_instr, trig_en, trig_instr, trig_mask, arm, rd_req,
      output rd_valid, rd_pc, rd_instr, count, state, overflow
   );
endinterface

// File: rtl/instr_trace_buf.sv
// Debug trace buffer: circular capture of retired PC/instruction pairs,
// freezes POST_TRIG retirements after a masked trigger match, then replays
// the held entries oldest-first. Never back-pressures the pipeline.
module instr_trace_buf #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int POST_TRIG = 8
) (
   input  logic               clk,
   input  logic               rst,
   instr_trace_buf_if.slave   bus
);
   typedef enum logic [1:0] {
      ARMED  = 2'b00,
      POST   = 2'b01,
      FROZEN = 2'b10
   } state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_q;
   logic [AW-1:0] post_cnt;
   logic          ovf_q;
   logic          rd_valid_q;
   logic [31:0]   rd_pc_q, rd_instr_q;
   logic [63:0]   mem [DEPTH];

   logic          cap, hit, pop;

   // Qualify capture, trigger match and pop; arm overrides everything.
   always_comb begin
      cap     = 1'b0;
      hit     = 1'b0;
      pop     = 1'b0;
      state_d = state_q;
      cap = bus.wb_valid && !bus.arm && (state_q != FROZEN);
      hit = (state_q == ARMED) && bus.trig_en && bus.wb_valid &&
            (((bus.wb_instr ^ bus.trig_instr) & bus.trig_mask) == 32'h0);
      pop = (state_q == FROZEN) && bus.rd_req && !bus.arm && (count_q != '0);
      if (bus.arm) begin
         state_d = ARMED;
      end else begin
         case (state_q)
            ARMED:   if (hit) state_d = (POST_TRIG == 0) ? FROZEN : POST;
            POST:    if (cap && post_cnt == AW'(1)) state_d = FROZEN;
            FROZEN:  state_d = FROZEN;
            default: state_d = ARMED;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARMED;
      else     state_q <= state_d;
   end

   // Pointers, occupancy, post-trigger countdown and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         post_cnt <= '0;
         ovf_q    <= 1'b0;
      end else if (bus.arm) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         post_cnt <= '0;
         ovf_q    <= 1'b0;
      end else if (cap) begin
         wr_ptr <= wr_ptr + 1'b1;
         // A full buffer drops its oldest entry to make room.
         if (count_q == FULL) begin
            rd_ptr <= rd_ptr + 1'b1;
            ovf_q  <= 1'b1;
         end else begin
            count_q <= count_q + 1'b1;
         end
         if (hit)                   post_cnt <= AW'(POST_TRIG);
         else if (state_q == POST)  post_cnt <= post_cnt - 1'b1;
      end else if (pop) begin
         rd_ptr  <= rd_ptr + 1'b1;
         count_q <= count_q - 1'b1;
      end
   end

   // Entry storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (cap) mem[wr_ptr] <= {bus.wb_pc, bus.wb_instr};
   end

   // Registered readout: one-cycle valid pulse, data holds between pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_pc_q    <= '0;
         rd_instr_q <= '0;
      end else begin
         rd_valid_q <= pop;
         if (pop) begin
            rd_pc_q    <= mem[rd_ptr][63:32];
            rd_instr_q <= mem[rd_ptr][31:0];
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_pc    = rd_pc_q;
   assign bus.rd_instr = rd_instr_q;
   assign bus.count    = count_q;
   assign bus.state    = state_q;
   assign bus.overflow = ovf_q;
endmodule
